// File: rtl/aux_step_counter_pkg.sv
// aux_cnt_pkg: shared encodings for the auxiliary step counter.
//   MODE_WRAP / MODE_SAT : mode_i encodings (modulo wrap vs clip at 0/MAX)
//   DIR_UP / DIR_DN      : up_i encodings
//   cnt_op_e             : which update the counter applies on a given edge
package aux_cnt_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;

  // Update selected by the priority mux, highest priority first.
  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LOAD = 2'd1,
    OP_STEP = 2'd2,
    OP_HOLD = 2'd3
  } cnt_op_e;

  // Priority decode: clear beats load beats enable beats hold.
  function automatic cnt_op_e sel_op(input logic clr, input logic load, input logic en);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (en)   return OP_STEP;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/aux_step_counter_if.sv
// aux_step_counter_if: control/status bundle of the auxiliary step counter.
//   clr_i, load_i, load_val_i, en_i, up_i, mode_i, step_i : control into the counter
//   cnt_o, tc_o, ovf_o, err_o                             : registered status out
// Modports: master drives control and observes status; slave is the counter.
interface aux_step_counter_if #(
  parameter int WIDTH  = 6,
  parameter int STEP_W = 3
);
  logic              clr_i;
  logic              load_i;
  logic [WIDTH-1:0]  load_val_i;
  logic              en_i;
  logic              up_i;
  logic              mode_i;
  logic [STEP_W-1:0] step_i;
  logic [WIDTH-1:0]  cnt_o;
  logic              tc_o;
  logic              ovf_o;
  logic              err_o;

  modport master (
    output clr_i, load_i, load_val_i, en_i, up_i, mode_i, step_i,
    input  cnt_o, tc_o, ovf_o, err_o
  );

  modport slave (
    input  clr_i, load_i, load_val_i, en_i, up_i, mode_i, step_i,
    output cnt_o, tc_o, ovf_o, err_o
  );
endinterface

// File: rtl/aux_step_counter_next.sv
// aux_step_next: combinational next-count for one enabled step.
//   cnt  : current count (always <= MAX)
//   step : step amount, zero-extended
//   up   : DIR_UP / DIR_DN
//   mode : MODE_WRAP / MODE_SAT
//   nxt  : count after the step
//   tc   : step crossed a bound (wrapped or clipped)
//   err  : step larger than MAX, rejected; count holds
// All arithmetic is WIDTH+1 bits so the carry out of cnt+step is visible.
module aux_step_next
  import aux_cnt_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int MAX    = 63,
  parameter int STEP_W = 3
) (
  input  logic [WIDTH-1:0]  cnt,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  logic              mode,
  output logic [WIDTH-1:0]  nxt,
  output logic              tc,
  output logic              err
);

  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MAX + 1);

  logic [WIDTH:0] cnt_x, step_x;
  logic [WIDTH:0] up_sum, up_wrap, dn_diff, dn_wrap;

  assign cnt_x  = {1'b0, cnt};
  assign step_x = {{(WIDTH+1-STEP_W){1'b0}}, step};

  // Wrap results only matter when the plain result left [0, MAX]; in that
  // case they land back in range, so dropping the top bit is lossless.
  assign up_sum  = cnt_x + step_x;
  assign up_wrap = up_sum - MOD_X;
  assign dn_diff = cnt_x - step_x;
  assign dn_wrap = cnt_x + MOD_X - step_x;

  always_comb begin
    nxt = cnt;
    tc  = 1'b0;
    err = 1'b0;
    if (step_x == '0) begin
      // zero step: hold, no flags
    end else if (step_x > MAX_X) begin
      err = 1'b1;
    end else if (up == DIR_UP) begin
      if (up_sum > MAX_X) begin
        tc  = 1'b1;
        nxt = (mode == MODE_SAT) ? MAX_X[WIDTH-1:0] : up_wrap[WIDTH-1:0];
      end else begin
        nxt = up_sum[WIDTH-1:0];
      end
    end else begin
      if (cnt_x < step_x) begin
        tc  = 1'b1;
        nxt = (mode == MODE_SAT) ? '0 : dn_wrap[WIDTH-1:0];
      end else begin
        nxt = dn_diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/aux_step_counter.sv
// aux_step_counter: modulo-(MAX+1) up/down counter with programmable step,
// wrap/saturate mode, synchronous clear/load and tc/ovf/err flags.
//   clk  : clock, posedge
//   rstn : asynchronous active-low reset
//   bus  : control/status bundle (slave side), see aux_step_counter_if
// Update priority per edge: clear > load > enable > hold. tc_o and err_o are
// single-cycle pulses for the edge that caused them; ovf_o is sticky until
// clear or reset.
module aux_step_counter
  import aux_cnt_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int MAX     = 63,
  parameter int STEP_W  = 3,
  parameter int RST_VAL = 0
) (
  input  logic               clk,
  input  logic               rstn,
  aux_step_counter_if.slave  bus
);

  if (WIDTH < 2) begin : g_chk_width
    $error("aux_step_counter: WIDTH must be >= 2");
  end
  if (MAX < 0 || MAX > (2**WIDTH) - 1) begin : g_chk_max
    $error("aux_step_counter: MAX must lie in [0, 2**WIDTH-1]");
  end
  if (STEP_W < 1 || STEP_W > WIDTH) begin : g_chk_step
    $error("aux_step_counter: STEP_W must lie in [1, WIDTH]");
  end
  if (RST_VAL < 0 || RST_VAL > MAX) begin : g_chk_rst
    $error("aux_step_counter: RST_VAL must lie in [0, MAX]");
  end

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_nxt;
  logic             step_tc, step_err;
  cnt_op_e          op;

  aux_step_next #(
    .WIDTH  (WIDTH),
    .MAX    (MAX),
    .STEP_W (STEP_W)
  ) u_next (
    .cnt  (cnt_q),
    .step (bus.step_i),
    .up   (bus.up_i),
    .mode (bus.mode_i),
    .nxt  (step_nxt),
    .tc   (step_tc),
    .err  (step_err)
  );

  assign op = sel_op(bus.clr_i, bus.load_i, bus.en_i);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    err_d = 1'b0;
    ovf_d = ovf_q;
    unique case (op)
      OP_CLR: begin
        // clear wins even over an ovf set from the same edge
        cnt_d = RST_C;
        ovf_d = 1'b0;
      end
      OP_LOAD: begin
        // out-of-range loads clip to MAX and flag; they are not a wrap
        if ({1'b0, bus.load_val_i} > MAX_X) begin
          cnt_d = MAX_X[WIDTH-1:0];
          err_d = 1'b1;
        end else begin
          cnt_d = bus.load_val_i;
        end
      end
      OP_STEP: begin
        cnt_d = step_nxt;
        tc_d  = step_tc;
        err_d = step_err;
        if (step_tc) ovf_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= RST_C;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign bus.cnt_o = cnt_q;
  assign bus.tc_o  = tc_q;
  assign bus.ovf_o = ovf_q;
  assign bus.err_o = err_q;

endmodule

// File: tb/tb_aux_step_counter.sv
// tb_aux_step_counter: directed vector table, reset-mid-count sequence and a
// random run against a behavioural model, for WIDTH=6, MAX=9, STEP_W=3.
module tb_aux_step_counter;

  localparam int W    = 6;
  localparam int MAXV = 9;
  localparam int SW   = 3;

  logic clk;
  logic rstn;

  aux_step_counter_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  aux_step_counter #(
    .WIDTH   (W),
    .MAX     (MAXV),
    .STEP_W  (SW),
    .RST_VAL (0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit clr; bit load; int lv; bit en; bit up; bit mode; int st;
    int e_cnt; bit e_tc; bit e_ovf; bit e_err;
  } vec_t;

  typedef struct {
    int cnt; bit tc; bit ovf; bit err; int tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  // behavioural model state for the random run
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  int cov_up_wrap = 0, cov_up_sat = 0, cov_dn_wrap = 0, cov_dn_sat = 0, cov_ld_err = 0;

  task automatic chk(input string nm, input int tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, tag, act, exp);
    end
  endtask

  task automatic drive(input bit clr, input bit load, input int lv, input bit en,
                       input bit up, input bit mode, input int st);
    bus.clr_i      = clr;
    bus.load_i     = load;
    bus.load_val_i = W'(lv);
    bus.en_i       = en;
    bus.up_i       = up;
    bus.mode_i     = mode;
    bus.step_i     = SW'(st);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL scoreboard: empty when output due");
    end else begin
      e = sb.pop_front();
      chk("cnt", e.tag, int'(bus.cnt_o), e.cnt);
      chk("tc",  e.tag, int'(bus.tc_o),  int'(e.tc));
      chk("ovf", e.tag, int'(bus.ovf_o), int'(e.ovf));
      chk("err", e.tag, int'(bus.err_o), int'(e.err));
    end
  endtask

  // one clocked operation: drive at negedge, push expectation, compare after posedge
  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    drive(v.clr, v.load, v.lv, v.en, v.up, v.mode, v.st);
    e.cnt = v.e_cnt; e.tc = v.e_tc; e.ovf = v.e_ovf; e.err = v.e_err; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  function automatic vec_t mk(bit clr, bit load, int lv, bit en, bit up, bit mode, int st,
                              int e_cnt, bit e_tc, bit e_ovf, bit e_err);
    vec_t v;
    v.clr = clr; v.load = load; v.lv = lv; v.en = en; v.up = up; v.mode = mode; v.st = st;
    v.e_cnt = e_cnt; v.e_tc = e_tc; v.e_ovf = e_ovf; v.e_err = e_err;
    return v;
  endfunction

  // reference model of one edge; returns expected flags, updates m_cnt/m_ovf
  task automatic model(input bit clr, input bit load, input int lv, input bit en,
                       input bit up, input bit mode, input int st,
                       output bit tc, output bit err);
    int n;
    tc = 1'b0; err = 1'b0;
    if (clr) begin
      m_cnt = 0; m_ovf = 1'b0;
    end else if (load) begin
      if (lv > MAXV) begin m_cnt = MAXV; err = 1'b1; cov_ld_err++; end
      else m_cnt = lv;
    end else if (en && st != 0) begin
      if (st > MAXV) begin
        err = 1'b1;
      end else if (up) begin
        n = m_cnt + st;
        if (n > MAXV) begin
          tc = 1'b1;
          if (mode) begin m_cnt = MAXV; cov_up_sat++; end
          else begin m_cnt = n % (MAXV + 1); cov_up_wrap++; end
        end else m_cnt = n;
      end else begin
        n = m_cnt - st;
        if (n < 0) begin
          tc = 1'b1;
          if (mode) begin m_cnt = 0; cov_dn_sat++; end
          else begin m_cnt = n + MAXV + 1; cov_dn_wrap++; end
        end else m_cnt = n;
      end
    end
    if (tc) m_ovf = 1'b1;
  endtask

  vec_t tbl[28];

  initial begin
    // fields: clr load lv en up mode st | cnt tc ovf err
    tbl[0]  = mk(0,1, 8,0,0,0,0,  8,0,0,0);  // load 8
    tbl[1]  = mk(0,0, 0,1,1,0,3,  1,1,1,0);  // 8+3 wraps to 1
    tbl[2]  = mk(0,0, 0,1,1,0,0,  1,0,1,0);  // step 0 holds, ovf sticky
    tbl[3]  = mk(0,1, 8,0,0,0,0,  8,0,1,0);
    tbl[4]  = mk(0,0, 0,1,1,0,1,  9,0,1,0);  // land on MAX: no tc
    tbl[5]  = mk(0,1, 1,0,0,0,0,  1,0,1,0);
    tbl[6]  = mk(0,0, 0,1,0,0,3,  8,1,1,0);  // 1-3 wraps to 8
    tbl[7]  = mk(0,1, 3,0,0,0,0,  3,0,1,0);
    tbl[8]  = mk(0,0, 0,1,0,0,3,  0,0,1,0);  // land on 0: no tc
    tbl[9]  = mk(0,1, 8,0,0,0,0,  8,0,1,0);
    tbl[10] = mk(0,0, 0,1,1,1,2,  9,1,1,0);  // saturate up
    tbl[11] = mk(0,0, 0,1,1,1,2,  9,1,1,0);  // at bound, tc each cycle
    tbl[12] = mk(0,0, 0,1,1,1,2,  9,1,1,0);
    tbl[13] = mk(0,0, 0,1,1,1,2,  9,1,1,0);
    tbl[14] = mk(0,1, 1,0,0,0,0,  1,0,1,0);
    tbl[15] = mk(0,0, 0,1,0,1,4,  0,1,1,0);  // saturate down
    tbl[16] = mk(0,0, 0,1,0,1,1,  0,1,1,0);  // at 0, outward
    tbl[17] = mk(1,1, 5,1,1,0,3,  0,0,0,0);  // clr beats load and en
    tbl[18] = mk(0,1,12,0,0,0,0,  9,0,0,1);  // illegal load clips, err
    tbl[19] = mk(0,0, 0,1,1,0,0,  9,0,0,0);  // en, step 0
    tbl[20] = mk(0,0, 0,0,1,0,3,  9,0,0,0);  // idle hold
    tbl[21] = mk(0,1, 9,0,0,0,0,  9,0,0,0);  // load MAX is legal
    tbl[22] = mk(0,0, 0,1,1,0,1,  0,1,1,0);  // 9+1 wraps to 0
    tbl[23] = mk(1,0, 0,0,0,0,0,  0,0,0,0);  // clr drops ovf
    tbl[24] = mk(0,0, 0,1,0,0,7,  3,1,1,0);  // 0-7 wraps to 3
    tbl[25] = mk(0,1, 2,0,0,0,0,  2,0,1,0);
    tbl[26] = mk(0,0, 0,1,1,0,7,  9,0,1,0);
    tbl[27] = mk(0,0, 0,1,0,0,7,  2,0,1,0);

    rstn = 1'b0;
    drive(0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 0, int'(bus.cnt_o), 0);
    chk("rst_tc",  0, int'(bus.tc_o),  0);
    chk("rst_ovf", 0, int'(bus.ovf_o), 0);
    chk("rst_err", 0, int'(bus.err_o), 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 28; i++) apply(tbl[i], i);

    // reset pulled mid-count: outputs must clear before the next edge
    apply(mk(0,1,4,0,0,0,0, 4,0,1,0), 100);
    apply(mk(0,0,0,1,1,0,1, 5,0,1,0), 101);
    @(negedge clk);
    drive(0,0,0,1,1,0,1);
    #2 rstn = 1'b0;
    #1;
    chk("async_cnt", 102, int'(bus.cnt_o), 0);
    chk("async_ovf", 102, int'(bus.ovf_o), 0);
    chk("async_tc",  102, int'(bus.tc_o),  0);
    @(negedge clk);
    drive(0,0,0,0,0,0,0);
    rstn = 1'b1;
    apply(mk(0,0,0,1,1,0,2, 2,0,0,0), 103);  // first edge after release counts

    // random run against the model
    m_cnt = 2; m_ovf = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      bit clr, load, en, up, mode, tc, err;
      int lv, st;
      exp_t e;
      clr  = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 7) == 0);
      lv   = $urandom_range(0, 15);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) != 0;
      mode = $urandom_range(0, 1) != 0;
      st   = $urandom_range(0, 7);
      @(negedge clk);
      drive(clr, load, lv, en, up, mode, st);
      model(clr, load, lv, en, up, mode, st, tc, err);
      e.cnt = m_cnt; e.tc = tc; e.ovf = m_ovf; e.err = err; e.tag = 1000 + i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      pop_cmp();
    end

    $display("coverage: up_wrap=%0d up_sat=%0d dn_wrap=%0d dn_sat=%0d load_err=%0d",
             cov_up_wrap, cov_up_sat, cov_dn_wrap, cov_dn_sat, cov_ld_err);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
